// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the iterative square-root block.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring shift-subtract step: brings in two radicand bits, yields one root bit.
module sqrt_step #(
  parameter int H = 4
) (
  input  logic [H:0]   rem_in,
  input  logic [H-1:0] root_in,
  input  logic [1:0]   pair,
  output logic [H:0]   rem_out,
  output logic         bit_out
);

  logic [H+2:0] shifted, trial, diff;

  assign shifted = {rem_in, pair};
  // Trial divisor is 4*root + 1 for the next candidate bit.
  assign trial   = {1'b0, root_in, 2'b01};
  assign diff    = shifted - trial;
  assign bit_out = shifted >= trial;
  // Partial remainder never exceeds 2*root, so H+1 bits always suffice.
  assign rem_out = (H+1)'(bit_out ? diff : shifted);

endmodule

// File: rtl/sqrt_iter.sv
// Iterative integer square root, one root bit per cycle, optional round-to-nearest.
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROUND = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   x_i,
  output logic               busy_o,
  output logic               valid_o,
  output logic [WIDTH/2-1:0] y_o,
  output logic [WIDTH/2:0]   rem_o
);

  localparam int H  = WIDTH / 2;
  localparam int CW = clog2(H + 1);

  state_t         state;
  logic [WIDTH-1:0] xs;
  logic [H-1:0]   root, root_next, y_fin;
  logic [H:0]     rem, rem_next, inc;
  logic [CW-1:0]  cnt;
  logic           root_bit;

  sqrt_step #(.H(H)) u_step (
    .rem_in  (rem),
    .root_in (root),
    .pair    (xs[WIDTH-1 -: 2]),
    .rem_out (rem_next),
    .bit_out (root_bit)
  );

  assign root_next = H'({root, root_bit});
  assign inc       = {1'b0, root_next} + (H+1)'(1);

  // Rounding uses the floor remainder; saturate when root+1 overflows H bits.
  always_comb begin
    y_fin = root_next;
    if (ROUND != 0 && rem_next > {1'b0, root_next})
      y_fin = inc[H] ? '1 : inc[H-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      y_o     <= '0;
      rem_o   <= '0;
      cnt     <= '0;
      xs      <= '0;
      root    <= '0;
      rem     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          valid_o <= 1'b0;
          if (start_i) begin
            xs     <= x_i;
            root   <= '0;
            rem    <= '0;
            cnt    <= CW'(H);
            busy_o <= 1'b1;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          xs   <= xs << 2;
          root <= root_next;
          rem  <= rem_next;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state   <= DONE;
            busy_o  <= 1'b0;
            valid_o <= 1'b1;
            y_o     <= y_fin;
            rem_o   <= rem_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
